// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier: C = A*B on LANES MAC units, valid/ready in and out.
// Build option: define MATMUL_SIGNED_EN for two's-complement operands and result.
module matrix_mult_seq #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LANES     = N,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A [N][N],
  input  logic [WIDTH-1:0]     B [N][N],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] C [N][N]
);

  localparam int unsigned GROUPS = N * N / LANES;
  localparam int unsigned KW     = $clog2(N);
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned PW     = 2 * WIDTH;

  if (N < 2) begin : g_bad_n
    $fatal(1, "matrix_mult_seq: N must be at least 2");
  end
  if ((N * N) % LANES != 0) begin : g_bad_lanes
    $fatal(1, "matrix_mult_seq: LANES must divide N*N");
  end
  if (ACC_WIDTH < PW) begin : g_bad_acc
    $fatal(1, "matrix_mult_seq: ACC_WIDTH must be at least 2*WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e               state_q;
  logic                 out_valid_q;
  logic [KW-1:0]        k_q;
  logic [GW-1:0]        g_q;
  logic [WIDTH-1:0]     a_q [N][N];
  logic [WIDTH-1:0]     b_q [N][N];
  logic [ACC_WIDTH-1:0] c_q [N][N];
  logic [ACC_WIDTH-1:0] acc_q [LANES];

  logic [KW-1:0]        row [LANES];
  logic [KW-1:0]        col [LANES];
  logic [PW-1:0]        a_op [LANES];
  logic [PW-1:0]        b_op [LANES];
  logic [PW-1:0]        prod [LANES];
  logic [ACC_WIDTH-1:0] acc_sum [LANES];

  // Operands are extended to full product width first, so one multiplier serves both builds.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      row[l] = KW'((32'(g_q) * LANES + l) / N);
      col[l] = KW'((32'(g_q) * LANES + l) % N);
`ifdef MATMUL_SIGNED_EN
      a_op[l]    = PW'($signed(a_q[row[l]][k_q]));
      b_op[l]    = PW'($signed(b_q[k_q][col[l]]));
      prod[l]    = a_op[l] * b_op[l];
      acc_sum[l] = acc_q[l] + ACC_WIDTH'($signed(prod[l]));
`else
      a_op[l]    = PW'(a_q[row[l]][k_q]);
      b_op[l]    = PW'(b_q[k_q][col[l]]);
      prod[l]    = a_op[l] * b_op[l];
      acc_sum[l] = acc_q[l] + ACC_WIDTH'(prod[l]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      k_q         <= '0;
      g_q         <= '0;
      for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            k_q     <= '0;
            g_q     <= '0;
            for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
            state_q <= StCompute;
          end
        end
        StCompute: begin
          k_q <= k_q + KW'(1);
          for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= acc_sum[l];
          if (k_q == KW'(N - 1)) begin
            k_q <= '0;
            g_q <= g_q + GW'(1);
            for (int unsigned l = 0; l < LANES; l++) begin
              c_q[row[l]][col[l]] <= acc_sum[l];
              acc_q[l]            <= '0;
            end
            if (g_q == GW'(GROUPS - 1)) begin
              g_q         <= '0;
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign C         = c_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: job-level reference model checked every cycle plus directed vectors.
module tb_matrix_mult_seq;
  localparam int N         = 4;
  localparam int WIDTH     = 16;
  localparam int LANES     = 4;
  localparam int ACC_WIDTH = 34;
  localparam int LAT       = N * N * N / LANES;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     A [N][N];
  logic [WIDTH-1:0]     B [N][N];
  logic [ACC_WIDTH-1:0] C [N][N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_mult_seq #(
    .N(N), .WIDTH(WIDTH), .LANES(LANES), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy, 2 result presented.
  int                   m_phase = 0;
  int                   m_left  = 0;
  logic [ACC_WIDTH-1:0] m_c [N][N];

  function automatic longint elem(input logic [WIDTH-1:0] v);
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  function automatic logic [ACC_WIDTH-1:0] dot(input int i, input int j);
    longint s = 0;
    for (int k = 0; k < N; k++) s += elem(A[i][k]) * elem(B[k][j]);
    return ACC_WIDTH'(s);
  endfunction

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m_c[i][j] = '0;
        A[i][j]   = '0;
        B[i][j]   = '0;
      end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) m_c[i][j] = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m_c[i][j] = dot(i, j);
          m_left  = LAT;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare; C is only defined outside the busy window.
  always @(negedge clk) begin : cmp
    int nbad;
    if (rst_n) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase != 1) begin
        nbad = 0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (C[i][j] !== m_c[i][j]) begin
              if (nbad == 0)
                $display("FAIL c_matrix[%0d][%0d] got=%0h want=%0h", i, j, C[i][j], m_c[i][j]);
              nbad++;
            end
        total++;
        if (nbad != 0) bad++;
      end
    end
  end

  task automatic submit();
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("done_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_release", in_ready, 1'b1);
  endtask

  task automatic set_b_diag(input int d);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) B[i][j] = (i == j) ? WIDTH'(d) : '0;
  endtask

  initial begin
    int lat;
    logic [ACC_WIDTH-1:0] held;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c00", C[0][0], '0);
    chk("rst_c33", C[3][3], '0);

    // Identity: A[i][j]=i+j
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) A[i][j] = WIDTH'(i + j);
    set_b_diag(1);
    submit();
    wait_done(lat);
    chk("latency", lat, 16);
    chk("ident_c32", C[3][2], 5);
    chk("ident_c01", C[0][1], 1);
    release_out();

    // Max values, then backpressure
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 16'hFFFF;
        B[i][j] = 16'hFFFF;
      end
    submit();
    wait_done(lat);
`ifdef MATMUL_SIGNED_EN
    chk("max_c00", C[0][0], 34'h4);
    chk("max_c23", C[2][3], 34'h4);
`else
    chk("max_c00", C[0][0], 34'h3FFF80004);
    chk("max_c23", C[2][3], 34'h3FFF80004);
`endif
    held = C[1][2];
    repeat (10) @(negedge clk);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_c12_stable", C[1][2], held);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released_in_ready", in_ready, 1'b1);
    chk("bp_released_out_valid", out_valid, 1'b0);

    // Sign interpretation: A all 0xFFFF, B identity
    set_b_diag(1);
    submit();
    wait_done(lat);
`ifdef MATMUL_SIGNED_EN
    chk("neg1_c11", C[1][1], 34'h3FFFFFFFF);
`else
    chk("neg1_c11", C[1][1], 34'hFFFF);
`endif
    release_out();

    // Reset in the middle of COMPUTE
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) A[i][j] = WIDTH'(i * N + j + 1);
    set_b_diag(1);
    submit();
    repeat (6) @(negedge clk);
    chk("pre_reset_c00", C[0][0], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_c00", C[0][0], '0);
    chk("midrst_c03", C[0][3], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: B = I then B = 2I; operand changes mid-job must be ignored
    submit();
    wait_done(lat);
    chk("job1_c23", C[2][3], 12);
    release_out();
    set_b_diag(2);
    submit();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 16'h1234;
        B[i][j] = 16'h0101;
      end
    wait_done(lat);
    chk("job2_c23", C[2][3], 24);
    chk("job2_c00", C[0][0], 2);
    chk("job2_c33", C[3][3], 32);
    release_out();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
